stream_aggregate: RTL

//  Packs a narrow per-cycle ingress stream (RMII dibits by default) into OUT_WIDTH-bit words.

---
 rtl/aggregate_pkg.sv | 16 +
 rtl/agg_out_stage.sv | 74 +++++++
 rtl/stream_aggregate.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/aggregate_pkg.sv
// Shared types and sizing helpers for the stream_aggregate packer.
package aggregate_pkg;

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,
    IDLE     = 2'd1,
    COLLECT  = 2'd2,
    SKIP     = 2'd3
  } agg_state_e;

  // Width needed to hold a unit count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/agg_out_stage.sv
// Output holding register: presents one word until accepted, flags words lost while full.
module agg_out_stage #(
  parameter int DW = 32,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          push_last_i,
  input  logic [CW-1:0] push_cnt_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  output logic [CW-1:0] cnt_o,
  output logic          overflow_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          accept_s;

  // Next-state: load on push when free or draining, otherwise drop and flag.
  always_comb begin
    accept_s = valid_q && ready_i;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push_i) begin
      if (!valid_q || accept_s) begin
        valid_d = 1'b1;
        data_d  = push_data_i;
        last_d  = push_last_i;
        cnt_d   = push_cnt_i;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign last_o     = last_q;
  assign cnt_o      = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/stream_aggregate.sv
// Packs a narrow ingress stream into MSB-first words, marking the last word of each frame.
module stream_aggregate
  import aggregate_pkg::*;
#(
  parameter int IN_WIDTH      = 2,
  parameter int OUT_WIDTH     = 32,
  parameter int FIRST_ONLY    = 0,
  parameter int FLUSH_PARTIAL = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           axiiv,
  input  logic [IN_WIDTH-1:0]                            axiid,
  input  logic                                           axior,
  output logic                                           axiov,
  output logic [OUT_WIDTH-1:0]                           axiod,
  output logic                                           axiolast,
  output logic [cnt_width(OUT_WIDTH/IN_WIDTH)-1:0]       axiocnt,
  output logic                                           overflow
);

  localparam int N  = OUT_WIDTH / IN_WIDTH;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if ((OUT_WIDTH % IN_WIDTH) != 0) begin : g_width_chk
    $error("stream_aggregate: OUT_WIDTH must be a multiple of IN_WIDTH");
  end
  if (OUT_WIDTH < 2 * IN_WIDTH) begin : g_ratio_chk
    $error("stream_aggregate: OUT_WIDTH must hold at least two input units");
  end

  agg_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] shift_q, shift_d;
  logic [OUT_WIDTH-1:0] pend_q, pend_d;
  logic                 pend_v_q, pend_v_d;

  logic                 take_s, word_done_s;
  logic [OUT_WIDTH-1:0] full_word_s, partial_word_s;
  logic [31:0]          shamt_s;

  logic                 push_s;
  logic [OUT_WIDTH-1:0] push_data_s;
  logic                 push_last_s;
  logic [CW-1:0]        push_cnt_s;

  assign take_s         = ((state_q == IDLE) || (state_q == COLLECT)) && axiiv;
  assign word_done_s    = take_s && (cnt_q == CNT_LAST);
  assign full_word_s    = {shift_q[OUT_WIDTH-IN_WIDTH-1:0], axiid};
  // Left-justify the collected units; stale high bits fall off, low bits zero-fill.
  assign shamt_s        = 32'(IN_WIDTH) * (32'(N) - 32'(cnt_q));
  assign partial_word_s = shift_q << shamt_s;

  // Packing, pending-word release and frame FSM next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_v_d    = 1'b0;
    push_s      = 1'b0;
    push_data_s = '0;
    push_last_s = 1'b0;
    push_cnt_s  = '0;

    if (take_s) begin
      shift_d = full_word_s;
      cnt_d   = word_done_s ? '0 : (cnt_q + CNT_ONE);
    end else begin
      shift_d = shift_q;
    end

    if (FIRST_ONLY == 0) begin
      if (word_done_s) begin
        pend_d   = full_word_s;
        pend_v_d = 1'b1;
      end else begin
        pend_d = pend_q;
      end
      // A full word waits one cycle so the following input can tell us whether it ends the frame.
      if (pend_v_q) begin
        push_s      = 1'b1;
        push_data_s = pend_q;
        push_last_s = !axiiv;
        push_cnt_s  = CNT_FULL;
      end else if ((state_q == COLLECT) && !axiiv && (cnt_q != '0) && (FLUSH_PARTIAL != 0)) begin
        push_s      = 1'b1;
        push_data_s = partial_word_s;
        push_last_s = 1'b1;
        push_cnt_s  = cnt_q;
      end else begin
        push_s = 1'b0;
      end
    end else begin
      if (word_done_s) begin
        push_s      = 1'b1;
        push_data_s = full_word_s;
        push_last_s = 1'b0;
        push_cnt_s  = CNT_FULL;
      end else begin
        push_s = 1'b0;
      end
    end

    case (state_q)
      WAIT_GAP: begin
        if (!axiiv) state_d = IDLE;
        else        state_d = WAIT_GAP;
      end
      IDLE: begin
        if (axiiv) state_d = COLLECT;
        else       state_d = IDLE;
      end
      COLLECT: begin
        if (!axiiv) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if ((FIRST_ONLY != 0) && word_done_s) begin
          state_d = SKIP;
        end else begin
          state_d = COLLECT;
        end
      end
      SKIP: begin
        if (!axiiv) state_d = IDLE;
        else        state_d = SKIP;
      end
      default: begin
        state_d = WAIT_GAP;
        cnt_d   = '0;
      end
    endcase
  end

  // Packer state registers; reset discards any frame and pending word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_GAP;
      cnt_q    <= '0;
      shift_q  <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  agg_out_stage #(
    .DW (OUT_WIDTH),
    .CW (CW)
  ) u_out (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .push_last_i (push_last_s),
    .push_cnt_i  (push_cnt_s),
    .ready_i     (axior),
    .valid_o     (axiov),
    .data_o      (axiod),
    .last_o      (axiolast),
    .cnt_o       (axiocnt),
    .overflow_o  (overflow)
  );

endmodule
